// File: rtl/pic8_controller.sv
// pic8_controller: eight-input programmable interrupt controller.
// Edge-latched pending bits, CPU-writable mask, nested in-service register
// with irq[0] as the highest priority, and specific / non-specific EOI.
// Two memory-mapped words: a0=0 mask, a0=1 status (read) / EOI (write).
module pic8_controller #(
  parameter int          NUM_IRQ      = 8,
  parameter logic [15:0] SPURIOUS_VEC = 16'h0007,
  parameter logic [7:0]  MASK_RESET   = 8'hFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_IRQ-1:0]   irq,
  output logic                 int_out,
  input  logic                 intack,
  output logic [15:0]          vector,
  input  logic                 cs,
  input  logic                 a0,
  input  logic                 wr,
  input  logic [15:0]          wdata,
  output logic [15:0]          rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ACKW = 2'd2;

  // Index of the lowest set bit (highest priority); 0 when none is set.
  function automatic logic [2:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = i[2:0];
      end
    end
    return idx;
  endfunction

  logic [NUM_IRQ-1:0] pending_r;
  logic [NUM_IRQ-1:0] isr_r;
  logic [NUM_IRQ-1:0] mask_r;
  logic [NUM_IRQ-1:0] irq_prev_r;
  logic [2:0]         vec_reg_r;
  logic [1:0]         state_r;
  logic               int_out_r;

  logic [NUM_IRQ-1:0] rise_s;
  logic [NUM_IRQ-1:0] prio_ok_s;
  logic [NUM_IRQ-1:0] eligible_s;
  logic               any_eligible_s;
  logic [2:0]         winner_s;
  logic [1:0]         next_state_s;
  logic [2:0]         vec_next_s;
  logic               ack_s;
  logic [NUM_IRQ-1:0] ack_bit_s;
  logic               mask_we_s;
  logic               eoi_we_s;
  logic [NUM_IRQ-1:0] eoi_clr_s;
  logic               unused_wdata_s;

  // Upper write-data bits carry no meaning for either register.
  assign unused_wdata_s = ^wdata[14:8];

  assign rise_s         = irq & ~irq_prev_r;
  assign mask_we_s      = cs & wr & ~a0;
  assign eoi_we_s       = cs & wr & a0;
  assign eligible_s     = pending_r & ~mask_r & prio_ok_s;
  assign any_eligible_s = |eligible_s;
  assign winner_s       = lowest_idx(eligible_s);
  assign ack_bit_s      = ack_s ? (8'd1 << vec_reg_r) : 8'd0;
  assign int_out        = int_out_r;

  // Only indices strictly above (more urgent than) the active in-service level may interrupt.
  always_comb begin
    logic seen_v;
    seen_v    = 1'b0;
    prio_ok_s = 8'd0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      seen_v       = seen_v | isr_r[i];
      prio_ok_s[i] = ~seen_v;
    end
  end

  // EOI decode: non-specific clears the lowest set isr bit, specific clears the addressed bit.
  always_comb begin
    if (!eoi_we_s) begin
      eoi_clr_s = 8'd0;
    end else if (wdata[15]) begin
      eoi_clr_s = isr_r & (~isr_r + 8'd1);
    end else begin
      eoi_clr_s = 8'd1 << wdata[2:0];
    end
  end

  // Request/acknowledge sequencing; vec_reg tracks the winner until the ack edge.
  always_comb begin
    next_state_s = state_r;
    vec_next_s   = vec_reg_r;
    ack_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_eligible_s) begin
          next_state_s = ST_REQ;
          vec_next_s   = winner_s;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (intack) begin
          ack_s        = 1'b1;
          next_state_s = ST_ACKW;
        end else if (!any_eligible_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_REQ;
          vec_next_s   = winner_s;
        end
      end
      ST_ACKW: begin
        if (!intack) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_ACKW;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, edge detector, pending/isr/mask updates; new edges win over ack clears, ack wins over EOI.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r  <= 8'd0;
      isr_r      <= 8'd0;
      mask_r     <= MASK_RESET;
      irq_prev_r <= 8'd0;
      vec_reg_r  <= 3'd0;
      state_r    <= ST_IDLE;
      int_out_r  <= 1'b0;
    end else begin
      irq_prev_r <= irq;
      pending_r  <= (pending_r & ~ack_bit_s) | rise_s;
      isr_r      <= (isr_r & ~eoi_clr_s) | ack_bit_s;
      if (mask_we_s) begin
        mask_r <= wdata[7:0];
      end else begin
        mask_r <= mask_r;
      end
      vec_reg_r  <= vec_next_s;
      state_r    <= next_state_s;
      int_out_r  <= (next_state_s == ST_REQ);
    end
  end

  // Vector is only meaningful while acknowledging a committed request.
  always_comb begin
    if (intack && (state_r == ST_REQ)) begin
      vector = {13'd0, vec_reg_r};
    end else begin
      vector = SPURIOUS_VEC;
    end
  end

  // Register read multiplexer.
  always_comb begin
    rdata = 16'h0000;
    if (cs) begin
      case (a0)
        1'b0:    rdata = {8'h00, mask_r};
        1'b1:    rdata = {isr_r, pending_r};
        default: rdata = 16'h0000;
      endcase
    end else begin
      rdata = 16'h0000;
    end
  end

endmodule

// File: doc/pic8_controller.md
Name: pic8_controller

Overview:
- Eight-input programmable interrupt controller between peripheral IRQ lines (e.g. switchbank interrupt on irq[2]) and the mammal CPU's INT/intack pins.
- Replaces the fixed combinational priority mux in the top level.
- Adds edge-latched pending bits, a CPU-writable mask, an in-service register with nested priority, and an end-of-interrupt (EOI) command.
- Memory-mapped as two words selected by cs and a0.

Parameters:
- NUM_IRQ, 8, number of request lines; fixed at 8 for this revision.
- SPURIOUS_VEC, 16'h0007, vector returned on intack when no request is committed.
- MASK_RESET, 8'hFF, mask register value after reset (1 = masked).

Ports:
- clk  in  1  system clock; all state on the rising edge
- reset  in  1  asynchronous, active-high reset
- irq  in  8  level request lines; irq[0] is highest priority
- int_out  out  1  interrupt request to the CPU INT pin
- intack  in  1  CPU interrupt acknowledge; held high for at least one cycle
- vector  out  16  interrupt number; valid combinationally while intack=1
- cs  in  1  register select, decoded from the CPU address by the top level
- a0  in  1  0 = mask register, 1 = status/EOI register
- wr  in  1  write strobe (memwt qualified by cs)
- wdata  in  16  CPU write data
- rdata  out  16  read data for the CPU input multiplexer

Behaviour:
- Reset (asynchronous):
  - pending=0, isr=0, mask=MASK_RESET, irq_prev=0, vec_reg=0, state=IDLE.
  - int_out=0; rdata and vector are combinational from the reset state.
- Edge capture:
  - irq_prev <= irq every cycle; pending[i] is set when irq[i]=1 and irq_prev[i]=0.
  - Holding a level high does not re-request.
- Eligibility:
  - eligible[i] = pending[i] & ~mask[i] & (i < index of the highest-priority set isr bit).
  - With isr empty, every index qualifies.
  - winner = lowest eligible index.
- FSM:
  - IDLE: int_out=0. If any eligible: vec_reg <= winner, go to REQ.
  - REQ: int_out=1. Each cycle vec_reg <= current winner, so a higher-priority arrival preempts before ack.
    - If no eligible and intack=0 (e.g. masked by a write): go to IDLE.
    - If intack=1 at a clock edge: pending[vec_reg] <= 0, isr[vec_reg] <= 1, go to ACKW.
  - ACKW: int_out=0. Remain until intack=0, then go to IDLE.
- Latency: irq[i] sampled high at edge n sets pending at edge n; state becomes REQ at edge n+1; int_out is high in the cycle after edge n+1.
- Vector:
  - vector = {13'b0, vec_reg} while intack=1 and state=REQ.
  - Otherwise vector = SPURIOUS_VEC, with no state change.
  - Only the low 3 bits are meaningful; the upper bits are always 0.
- Register reads:
  - a0=0: rdata = {8'h00, mask}.
  - a0=1: rdata = {isr, pending}.
  - cs=0: rdata = 16'h0000.
- Register writes (cs & wr):
  - a0=0: mask <= wdata[7:0].
  - a0=1, wdata[15]=1: non-specific EOI; clears the highest-priority set isr bit.
  - a0=1, wdata[15]=0: specific EOI; clears isr[wdata[2:0]].
  - EOI with isr empty or the bit already clear: no effect.
- Simultaneous events:
  - A new edge on irq[i] in the same cycle its pending bit is cleared by ack leaves pending[i]=1 (set wins).
  - EOI and ack in the same cycle: the EOI clear applies first, then isr[vec_reg] is set (the ack bit survives).
  - A mask write in the same cycle as intack does not cancel the in-flight ack.
- Reset while in REQ or ACKW: immediate return to IDLE; int_out drops asynchronously.

Test Plan:
- Single request: reset, write mask=8'h00, pulse irq[2] -> int_out high in the 2nd cycle after the edge; intack -> vector=16'h0002; next cycle int_out=0, status read = 16'h0400.
- Priority: raise irq[5] and irq[1] in the same cycle -> vector=16'h0001. Send non-specific EOI (wdata=16'h8000) -> int_out reasserts, vector=16'h0005.
- Nesting: irq[3] acked (isr=8'h08); pulse irq[4] -> int_out stays 0. Pulse irq[0] -> int_out=1, vector=16'h0000. After two non-specific EOIs, irq[4] is serviced.
- Masking: mask=8'h04, pulse irq[2] -> pending bit set, int_out=0. Write mask=8'h00 -> int_out high 2 cycles later. Write mask=8'hFF while in REQ -> int_out low next cycle.
- Spurious/edge: intack with no request -> vector=16'h0007 and no state change. Holding irq[6] high across its EOI -> no second request until irq[6] falls and rises again.
- Reset mid-operation: assert reset while int_out=1 -> int_out=0 immediately; status reads 16'h0000; mask reads 16'h00FF.
